// File: rtl/mem_access_unit.sv
// Load/store front end between MEM stage and word-wide data RAM; sub-word stores are read-modify-write.
// Latency from accept: error 1 cycle, load 2, word store 2, byte/half store 3 (cycles to the resp pulse).
// Accepts one request at a time (ready only in IDLE); the response pulse has no back-pressure.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [ADDR_WIDTH+1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    output logic                    o_resp_valid,
    output logic [DATA_WIDTH-1:0]   o_resp_rdata,
    output logic                    o_misaligned,
    output logic [ADDR_WIDTH-1:0]   o_ram_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_data,
    output logic                    o_ram_we,
    input  logic [DATA_WIDTH-1:0]   i_ram_data
);

    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    req_we_q, req_we_d;
    logic [1:0]              req_size_q, req_size_d;
    logic                    req_uns_q, req_uns_d;
    logic [ADDR_WIDTH+1:0]   req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic                    req_err;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   merged;

    // Ready is forced low while reset is held so nothing is accepted during reset
    assign o_req_ready  = (state_q == IDLE) && !i_rst;
    assign accept       = i_req_valid && o_req_ready;
    assign o_ram_addr   = req_addr_q[ADDR_WIDTH+1:2];
    assign o_ram_data   = buf_q;
    assign o_resp_rdata = rdata_q;

    // Alignment / size legality of the incoming request
    always_comb begin
        req_err = 1'b0;
        case (i_req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = i_req_addr[0];
            2'b10:   req_err = (i_req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                  state_d = RESP;
                    else if (!i_req_we)           state_d = LOAD;
                    else if (i_req_size == 2'b10) state_d = WRITE;
                    else                          state_d = MERGE;
                end
            end
            LOAD:    state_d = RESP;
            MERGE:   state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from state so async reset drops the write enable at once
    always_comb begin
        o_ram_we     = (state_q == WRITE);
        o_resp_valid = (state_q == RESP);
        o_misaligned = (state_q == RESP) && err_q;
    end

    // Lane selection, load extension and store-lane merge
    always_comb begin
        lane_byte = i_ram_data[7:0];
        case (req_addr_q[1:0])
            2'b00: lane_byte = i_ram_data[7:0];
            2'b01: lane_byte = i_ram_data[15:8];
            2'b10: lane_byte = i_ram_data[23:16];
            2'b11: lane_byte = i_ram_data[31:24];
            default: lane_byte = i_ram_data[7:0];
        endcase
        lane_half = req_addr_q[1] ? i_ram_data[31:16] : i_ram_data[15:0];

        case (req_size_q)
            2'b00:   load_ext = {{24{~req_uns_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{16{~req_uns_q & lane_half[15]}}, lane_half};
            default: load_ext = i_ram_data;
        endcase

        merged = i_ram_data;
        if (req_size_q == 2'b00) begin
            case (req_addr_q[1:0])
                2'b00: merged[7:0]   = buf_q[7:0];
                2'b01: merged[15:8]  = buf_q[7:0];
                2'b10: merged[23:16] = buf_q[7:0];
                2'b11: merged[31:24] = buf_q[7:0];
                default: merged = i_ram_data;
            endcase
        end else if (req_addr_q[1]) begin
            merged[31:16] = buf_q[15:0];
        end else begin
            merged[15:0] = buf_q[15:0];
        end
    end

    // Request latch on accept; load result captured in LOAD, write buffer merged in MERGE
    always_comb begin
        req_we_d   = req_we_q;
        req_size_d = req_size_q;
        req_uns_d  = req_uns_q;
        req_addr_d = req_addr_q;
        buf_d      = buf_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (accept) begin
            req_we_d   = i_req_we;
            req_size_d = i_req_size;
            req_uns_d  = i_req_unsigned;
            req_addr_d = i_req_addr;
            err_d      = req_err;
            rdata_d    = '0;
            // Store data parks in the write buffer; sub-word stores merge from it later
            if (i_req_we && !req_err) buf_d = i_req_wdata;
        end
        case (state_q)
            LOAD:    rdata_d = load_ext;
            MERGE:   buf_d   = merged;
            default: ;
        endcase
    end

    // Request / datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_we_q   <= 1'b0;
            req_size_q <= 2'b00;
            req_uns_q  <= 1'b0;
            req_addr_q <= '0;
            buf_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            req_we_q   <= req_we_d;
            req_size_q <= req_size_d;
            req_uns_q  <= req_uns_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a behavioural word RAM.
// Requests are pushed to a scoreboard at accept; responses popped and checked on the falling edge.
// Table-driven rows plus hand sequences for mid-operation reset and back-to-back requests.
module tb_mem_access_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [6:0]  i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_misaligned;
    logic [4:0]  o_ram_addr;
    logic [31:0] o_ram_data;
    logic        o_ram_we;
    logic [31:0] i_ram_data;

    always #5 i_clk = ~i_clk;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_misaligned(o_misaligned),
        .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data), .o_ram_we(o_ram_we),
        .i_ram_data(i_ram_data)
    );

    // Word RAM: combinational read, write on the rising edge
    logic [31:0] mem [32] = '{default: 32'h0};
    assign i_ram_data = mem[o_ram_addr];
    always @(posedge i_clk) if (o_ram_we) mem[o_ram_addr] <= o_ram_data;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
        int          wi;
        logic [31:0] wv;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          acc;
        int          we0;
        int          exp_w;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   we_cnt = 0;
    int   last_we_cyc = -1;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Response monitor: count RAM writes and check each response against the scoreboard
    always @(negedge i_clk) begin
        if (o_ram_we) begin
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (o_resp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=resp_pulse expected=no_resp (t=%0t)", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("resp_rdata", o_resp_rdata, mon_e.rdata);
                chk("resp_misaligned", {31'b0, o_misaligned}, {31'b0, mon_e.mis});
                chk("resp_latency", cyc - mon_e.acc + 1, mon_e.lat);
                chk("ram_write_count", we_cnt - mon_e.we0, mon_e.exp_w);
                if (mon_e.exp_w != 0) chk("ram_write_cycle", cyc - last_we_cyc, 1);
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [6:0] addr, input logic [31:0] wdata,
                          input logic [31:0] er, input logic em, input int el, input logic hold);
        int   n = 0;
        exp_t x;
        @(negedge i_clk);
        i_req_we = we; i_req_size = size; i_req_unsigned = uns;
        i_req_addr = addr; i_req_wdata = wdata; i_req_valid = 1'b1;
        while (!o_req_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_req_ready) begin
            chk("accept_timeout", {31'b0, o_req_ready}, 32'd1);
            i_req_valid = 1'b0;
            return;
        end
        x.rdata = er; x.mis = em; x.lat = el; x.acc = cyc + 1;
        x.we0 = we_cnt; x.exp_w = (we && !em) ? 1 : 0;
        sbq.push_back(x);
        @(posedge i_clk);
        if (!hold) begin
            @(negedge i_clk);
            i_req_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk(nm, sbq.size(), 0);
    endtask

    vec_t tv[20];
    vec_t bb[5];

    initial begin
        int we_save;
        // we size uns addr wdata exp_rdata mis lat word_idx word_val
        tv[0]  = '{1'b1, 2'b10, 1'b0, 7'h04, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1,  32'hDEADBEEF};
        tv[1]  = '{1'b1, 2'b00, 1'b0, 7'h05, 32'h1234565A, 32'h0,        1'b0, 3, 1,  32'hDEAD5AEF};
        tv[2]  = '{1'b0, 2'b00, 1'b0, 7'h07, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 1,  32'hDEAD5AEF};
        tv[3]  = '{1'b0, 2'b00, 1'b1, 7'h07, 32'h0,        32'h000000DE, 1'b0, 2, 1,  32'hDEAD5AEF};
        tv[4]  = '{1'b0, 2'b01, 1'b0, 7'h06, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 1,  32'hDEAD5AEF};
        tv[5]  = '{1'b0, 2'b10, 1'b0, 7'h04, 32'h0,        32'hDEAD5AEF, 1'b0, 2, 1,  32'hDEAD5AEF};
        tv[6]  = '{1'b0, 2'b01, 1'b1, 7'h06, 32'h0,        32'h0000DEAD, 1'b0, 2, 1,  32'hDEAD5AEF};
        tv[7]  = '{1'b0, 2'b00, 1'b0, 7'h04, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 1,  32'hDEAD5AEF};
        tv[8]  = '{1'b0, 2'b00, 1'b0, 7'h05, 32'h0,        32'h0000005A, 1'b0, 2, 1,  32'hDEAD5AEF};
        tv[9]  = '{1'b1, 2'b01, 1'b0, 7'h06, 32'hFFFF1234, 32'h0,        1'b0, 3, 1,  32'h12345AEF};
        tv[10] = '{1'b0, 2'b01, 1'b0, 7'h04, 32'h0,        32'h00005AEF, 1'b0, 2, 1,  32'h12345AEF};
        tv[11] = '{1'b0, 2'b00, 1'b1, 7'h06, 32'h0,        32'h00000034, 1'b0, 2, 1,  32'h12345AEF};
        tv[12] = '{1'b1, 2'b10, 1'b0, 7'h06, 32'h55555555, 32'h0,        1'b1, 1, 1,  32'h12345AEF};
        tv[13] = '{1'b0, 2'b01, 1'b0, 7'h05, 32'h0,        32'h0,        1'b1, 1, 1,  32'h12345AEF};
        tv[14] = '{1'b0, 2'b11, 1'b0, 7'h00, 32'h0,        32'h0,        1'b1, 1, 0,  32'h0};
        tv[15] = '{1'b1, 2'b10, 1'b0, 7'h7C, 32'hA5A5A5A5, 32'h0,        1'b0, 2, 31, 32'hA5A5A5A5};
        tv[16] = '{1'b0, 2'b00, 1'b0, 7'h7F, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 31, 32'hA5A5A5A5};
        tv[17] = '{1'b1, 2'b01, 1'b0, 7'h7C, 32'h00008001, 32'h0,        1'b0, 3, 31, 32'hA5A58001};
        tv[18] = '{1'b0, 2'b01, 1'b0, 7'h7C, 32'h0,        32'hFFFF8001, 1'b0, 2, 31, 32'hA5A58001};
        tv[19] = '{1'b1, 2'b11, 1'b0, 7'h00, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0,  32'h0};

        bb[0]  = '{1'b0, 2'b10, 1'b0, 7'h04, 32'h0,        32'h12345AEF, 1'b0, 2, 1,  32'h0};
        bb[1]  = '{1'b1, 2'b00, 1'b0, 7'h04, 32'h000000CC, 32'h0,        1'b0, 3, 1,  32'h0};
        bb[2]  = '{1'b0, 2'b00, 1'b1, 7'h04, 32'h0,        32'h000000CC, 1'b0, 2, 1,  32'h0};
        bb[3]  = '{1'b0, 2'b01, 1'b0, 7'h03, 32'h0,        32'h0,        1'b1, 1, 1,  32'h0};
        bb[4]  = '{1'b0, 2'b01, 1'b0, 7'h04, 32'h0,        32'h00005ACC, 1'b0, 2, 1,  32'h0};

        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'b00; i_req_unsigned = 1'b0;
        i_req_addr = 7'h0; i_req_wdata = 32'h0;
        i_rst = 1'b0;
        #1 i_rst = 1'b1;
        #3;
        chk("rst_ready", {31'b0, o_req_ready}, 32'd0);
        chk("rst_ram_we", {31'b0, o_ram_we}, 32'd0);
        chk("rst_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        chk("rst_misaligned", {31'b0, o_misaligned}, 32'd0);
        chk("rst_rdata", o_resp_rdata, 32'h0);
        chk("rst_ram_addr", {27'b0, o_ram_addr}, 32'h0);
        chk("rst_ram_data", o_ram_data, 32'h0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        #1 chk("ready_after_release", {31'b0, o_req_ready}, 32'd1);

        // Table-driven single requests
        for (int i = 0; i < 20; i++) begin
            do_req(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata,
                   tv[i].exp_rdata, tv[i].exp_mis, tv[i].exp_lat, 1'b0);
            wait_drain($sformatf("row%0d_drain", i));
            @(negedge i_clk);
            chk($sformatf("row%0d_ram_word", i), mem[tv[i].wi], tv[i].wv);
        end

        // Reset asserted while a byte store is in MERGE: no write, no response
        we_save = we_cnt;
        @(negedge i_clk);
        i_req_we = 1'b1; i_req_size = 2'b00; i_req_unsigned = 1'b0;
        i_req_addr = 7'h05; i_req_wdata = 32'h00000077; i_req_valid = 1'b1;
        chk("pre_abort_ready", {31'b0, o_req_ready}, 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("abort_ram_we", {31'b0, o_ram_we}, 32'd0);
        chk("abort_ready", {31'b0, o_req_ready}, 32'd0);
        chk("abort_ram_data", o_ram_data, 32'h0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        #1 chk("abort_ready_release", {31'b0, o_req_ready}, 32'd1);
        repeat (3) @(negedge i_clk);
        chk("abort_ram_word", mem[1], 32'h12345AEF);
        chk("abort_write_count", we_cnt - we_save, 0);

        // Back-to-back requests with valid held high
        for (int i = 0; i < 5; i++) begin
            do_req(bb[i].we, bb[i].size, bb[i].uns, bb[i].addr, bb[i].wdata,
                   bb[i].exp_rdata, bb[i].exp_mis, bb[i].exp_lat, 1'b1);
        end
        @(negedge i_clk);
        i_req_valid = 1'b0;
        wait_drain("b2b_drain");
        repeat (3) @(negedge i_clk);
        chk("b2b_ram_word", mem[1], 32'h12345ACC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
